regfile_write_arbiter: RTL and testbench

- Sequences the single register-file write port between two writeback requesters: the execute unit (single-cycle results) and the load unit (late memory returns).
- Keeps a 32-entry pending-load scoreboard. Decode uses it to detect RAW hazards. The arbiter uses it to enforce write-after-write ordering.
- Sits between the execute/load units and the register file write interface (rd, rdAddress, rdWriteEnable).

---
 rtl/regfile_write_arbiter.sv | 95 +++++++++
 tb/tb_regfile_write_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between execute and load writebacks.
// Tracks outstanding load destinations for decode RAW detection and execute WAW ordering.
module regfile_write_arbiter #(
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        exValid,
    input  logic [4:0]  exAddress,
    input  logic [31:0] exData,
    output logic        exReady,
    input  logic        ldValid,
    input  logic [4:0]  ldAddress,
    input  logic [31:0] ldData,
    output logic        ldReady,
    input  logic        issueValid,
    input  logic [4:0]  issueAddress,
    input  logic [4:0]  rs1Address,
    input  logic [4:0]  rs2Address,
    output logic        hazard,
    output logic [4:0]  rdAddress,
    output logic [31:0] rd,
    output logic        rdWriteEnable
);

    logic [31:0] pending_q, pending_d;
    logic        last_ld_q;
    logic        ex_elig, ld_elig;
    logic        grant_ex, grant_ld;

    always_comb begin
        // An execute write must not overtake an outstanding load to the same register.
        ex_elig  = exValid && !pending_q[exAddress];
        ld_elig  = ldValid;
        grant_ex = 1'b0;
        grant_ld = 1'b0;
        if (!reset) begin
            if (ex_elig && ld_elig) begin
                if (ROUND_ROBIN != 0 && last_ld_q) begin
                    grant_ex = 1'b1;
                end else begin
                    grant_ld = 1'b1;
                end
            end else begin
                grant_ex = ex_elig;
                grant_ld = ld_elig;
            end
        end
    end

    assign exReady = grant_ex;
    assign ldReady = grant_ld;

    assign hazard = (rs1Address != 5'd0 && pending_q[rs1Address]) ||
                    (rs2Address != 5'd0 && pending_q[rs2Address]);

    always_comb begin
        pending_d = pending_q;
        if (grant_ld) begin
            pending_d[ldAddress] = 1'b0;
        end
        // Set after clear so a load issued to the register just returned stays pending.
        if (issueValid && issueAddress != 5'd0) begin
            pending_d[issueAddress] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q     <= '0;
            last_ld_q     <= 1'b0;
            rdAddress     <= '0;
            rd            <= '0;
            rdWriteEnable <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (grant_ex || grant_ld) begin
                last_ld_q <= grant_ld;
            end
            if (grant_ex) begin
                rdAddress     <= exAddress;
                rd            <= exData;
                rdWriteEnable <= (exAddress != 5'd0);
            end else if (grant_ld) begin
                rdAddress     <= ldAddress;
                rd            <= ldData;
                rdWriteEnable <= (ldAddress != 5'd0);
            end else begin
                rdWriteEnable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized bench for regfile_write_arbiter against a per-register
// pending model and a queue of issued loads that return in order.
module tb_regfile_write_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        exValid, ldValid, issueValid;
    logic [4:0]  exAddress, ldAddress, issueAddress, rs1Address, rs2Address;
    logic [31:0] exData, ldData;
    logic        exReady, ldReady, hazard, rdWriteEnable;
    logic [4:0]  rdAddress;
    logic [31:0] rd;
    logic        exReady0, ldReady0, hazard0, rdWriteEnable0;
    logic [4:0]  rdAddress0;
    logic [31:0] rd0;

    always #5 clock = ~clock;

    regfile_write_arbiter #(.ROUND_ROBIN(1)) dut (
        .clock(clock), .reset(reset),
        .exValid(exValid), .exAddress(exAddress), .exData(exData), .exReady(exReady),
        .ldValid(ldValid), .ldAddress(ldAddress), .ldData(ldData), .ldReady(ldReady),
        .issueValid(issueValid), .issueAddress(issueAddress),
        .rs1Address(rs1Address), .rs2Address(rs2Address), .hazard(hazard),
        .rdAddress(rdAddress), .rd(rd), .rdWriteEnable(rdWriteEnable)
    );

    regfile_write_arbiter #(.ROUND_ROBIN(0)) dut0 (
        .clock(clock), .reset(reset),
        .exValid(exValid), .exAddress(exAddress), .exData(exData), .exReady(exReady0),
        .ldValid(ldValid), .ldAddress(ldAddress), .ldData(ldData), .ldReady(ldReady0),
        .issueValid(issueValid), .issueAddress(issueAddress),
        .rs1Address(rs1Address), .rs2Address(rs2Address), .hazard(hazard0),
        .rdAddress(rdAddress0), .rd(rd0), .rdWriteEnable(rdWriteEnable0)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    // Reference state for the round-robin instance.
    bit          pend [32];
    bit          last_was_ld;
    bit          m_we;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    bit          acc_ex, acc_ld;
    logic        obs_ex, obs_ld, obs_hz;
    bit          rr0_on = 1'b0;
    bit [4:0]    ldq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: check combinational outputs mid-cycle, then registered outputs after the edge.
    task automatic cycle();
        bit ex_ok, e_hz;
        @(negedge clock);
        ex_ok  = exValid && !pend[exAddress];
        acc_ex = 1'b0;
        acc_ld = 1'b0;
        if (!reset) begin
            if (ex_ok && ldValid) begin
                if (last_was_ld) acc_ex = 1'b1;
                else acc_ld = 1'b1;
            end else begin
                acc_ex = ex_ok;
                acc_ld = ldValid;
            end
        end
        e_hz = (rs1Address != 0 && pend[rs1Address]) || (rs2Address != 0 && pend[rs2Address]);
        obs_ex = exReady;
        obs_ld = ldReady;
        obs_hz = hazard;
        chk("exReady", {31'b0, exReady}, {31'b0, acc_ex});
        chk("ldReady", {31'b0, ldReady}, {31'b0, acc_ld});
        chk("hazard", {31'b0, hazard}, {31'b0, e_hz});
        if (acc_ex && acc_ld) chk("one_grant", 32'd1, 32'd0);
        if (rr0_on) begin
            chk("rr0_ldReady", {31'b0, ldReady0}, {31'b0, ldValid});
            chk("rr0_exReady", {31'b0, exReady0}, {31'b0, exValid && !ldValid});
            chk("rr0_hazard", {31'b0, hazard0}, 32'd0);
        end
        @(posedge clock);
        #1;
        if (reset) begin
            foreach (pend[i]) pend[i] = 1'b0;
            last_was_ld = 1'b0;
            m_we = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            if (acc_ex) begin
                m_we = (exAddress != 0); m_addr = exAddress; m_data = exData;
                last_was_ld = 1'b0;
            end else if (acc_ld) begin
                m_we = (ldAddress != 0); m_addr = ldAddress; m_data = ldData;
                last_was_ld = 1'b1;
                pend[ldAddress] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (issueValid && issueAddress != 0) pend[issueAddress] = 1'b1;
        end
        chk("rdWriteEnable", {31'b0, rdWriteEnable}, {31'b0, m_we});
        chk("rdAddress", {27'b0, rdAddress}, {27'b0, m_addr});
        chk("rd", rd, m_data);
    endtask

    initial begin
        reset = 1'b1;
        exValid = 0; exAddress = 0; exData = 0;
        ldValid = 0; ldAddress = 0; ldData = 0;
        issueValid = 0; issueAddress = 0; rs1Address = 0; rs2Address = 0;
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_we", {31'b0, rdWriteEnable}, 32'd0);
        chk("rst_rd", rd, 32'd0);

        // Execute alone.
        exValid = 1; exAddress = 5; exData = 32'hDEADBEEF;
        cycle();
        chk("t1_ack", {31'b0, obs_ex}, 32'd1);
        chk("t1_we", {31'b0, rdWriteEnable}, 32'd1);
        chk("t1_addr", {27'b0, rdAddress}, 32'd5);
        chk("t1_rd", rd, 32'hDEADBEEF);
        exValid = 0;
        cycle();

        // Conflict for three cycles on both arbitration policies.
        reset = 1;
        cycle();
        reset = 0;
        rr0_on = 1;
        exValid = 1; exAddress = 3; exData = 32'h11;
        ldValid = 1; ldAddress = 4; ldData = 32'h22;
        cycle();
        chk("rr_g0", {31'b0, obs_ld}, 32'd1);
        chk("rr_w0", rd, 32'h22);
        cycle();
        chk("rr_g1", {31'b0, obs_ex}, 32'd1);
        chk("rr_w1", rd, 32'h11);
        cycle();
        chk("rr_g2", {31'b0, obs_ld}, 32'd1);
        chk("rr0_w2", rd0, 32'h22);
        ldValid = 0;
        cycle();
        exValid = 0;
        cycle();
        chk("rr0_ex_late", rd0, 32'h11);
        chk("rr0_ex_addr", {27'b0, rdAddress0}, 32'd3);
        rr0_on = 0;

        // Load to x7 blocks an execute write to x7 until it returns.
        issueValid = 1; issueAddress = 7;
        cycle();
        issueValid = 0;
        rs1Address = 7;
        exValid = 1; exAddress = 7; exData = 32'h77;
        cycle();
        chk("x7_hz", {31'b0, obs_hz}, 32'd1);
        chk("x7_ex_blk", {31'b0, obs_ex}, 32'd0);
        ldValid = 1; ldAddress = 7; ldData = 32'h55;
        cycle();
        chk("x7_ld_ack", {31'b0, obs_ld}, 32'd1);
        chk("x7_first", rd, 32'h55);
        ldValid = 0;
        cycle();
        chk("x7_hz_clr", {31'b0, obs_hz}, 32'd0);
        chk("x7_second", rd, 32'h77);
        exValid = 0; rs1Address = 0;

        // x0 writes and issues are inert.
        exValid = 1; exAddress = 0; exData = 32'hFFFFFFFF;
        cycle();
        chk("x0_ack", {31'b0, obs_ex}, 32'd1);
        chk("x0_we", {31'b0, rdWriteEnable}, 32'd0);
        exValid = 0;
        issueValid = 1; issueAddress = 0;
        cycle();
        issueValid = 0;
        cycle();
        chk("x0_hz", {31'b0, obs_hz}, 32'd0);

        // Return and re-issue to x9 on the same edge keeps it pending.
        issueValid = 1; issueAddress = 9;
        cycle();
        ldValid = 1; ldAddress = 9; ldData = 32'h99;
        rs2Address = 9;
        cycle();
        chk("x9_ld_ack", {31'b0, obs_ld}, 32'd1);
        ldValid = 0; issueValid = 0;
        cycle();
        chk("x9_hz", {31'b0, obs_hz}, 32'd1);

        // Reset right after an accepted write drops it and clears the scoreboard.
        exValid = 1; exAddress = 2; exData = 32'h2222;
        cycle();
        chk("rst_pre_we", {31'b0, rdWriteEnable}, 32'd1);
        reset = 1;
        ldValid = 1; ldAddress = 4; ldData = 32'h44;
        cycle();
        chk("rst_ex_low", {31'b0, obs_ex}, 32'd0);
        chk("rst_ld_low", {31'b0, obs_ld}, 32'd0);
        chk("rst_drop_we", {31'b0, rdWriteEnable}, 32'd0);
        chk("rst_drop_rd", rd, 32'd0);
        reset = 0;
        exAddress = 3; exData = 32'h33;
        cycle();
        chk("rst_pend_clr", {31'b0, obs_hz}, 32'd0);
        chk("rst_first_ld", {31'b0, obs_ld}, 32'd1);
        ldValid = 0;
        cycle();

        // Randomized traffic with in-order load returns.
        for (int i = 0; i < 600; i++) begin
            if (acc_ld && ldq.size() > 0) void'(ldq.pop_front());
            if (issueValid && issueAddress != 0) ldq.push_back(issueAddress);
            if (!exValid || acc_ex) begin
                exValid = ($urandom_range(0, 9) < 6);
                exAddress = 5'($urandom_range(0, 7));
                exData = $urandom;
            end
            if (!(ldValid && !acc_ld)) begin
                if (ldq.size() > 0 && $urandom_range(0, 1) == 1) begin
                    ldValid = 1; ldAddress = ldq[0]; ldData = $urandom;
                end else begin
                    ldValid = 0;
                end
            end
            issueValid = ($urandom_range(0, 3) == 0);
            issueAddress = 5'($urandom_range(0, 7));
            rs1Address = 5'($urandom_range(0, 7));
            rs2Address = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
